pb_audio_port: RTL and testbench



---
 rtl/pb_audio_port.sv | 169 ++++++++++++++++
 tb/tb_pb_audio_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pb_audio_port.sv
// PicoBlaze I/O-mapped 16-bit audio sample FIFO with fill-level threshold interrupt.
// Define PB_AUDIO_OVFCNT_EN to add the saturating dropped-sample counter at offset 6.
module pb_audio_port #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         ADDR_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        read_strobe,
  output logic [7:0]  in_port,
  input  logic        write_strobe,
  input  logic [7:0]  out_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ARMED, PENDING, WAIT_LOW} irq_state_t;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              full_reg;
  logic              overflow_reg;
  logic              irq_en_reg;
  logic [7:0]        thresh_reg;
  logic [7:0]        in_port_reg;
  irq_state_t        irq_state_reg;

  logic        decoded, empty, push, pop, drop;
  logic        wr_ctrl, wr_thresh, flush, clr_ovf, cond;
  logic [2:0]  offset;
  logic [7:0]  count8, rd_mux, ovf_cnt;
  logic [15:0] head;

  assign decoded   = (port_id[7:3] == BASE_ADDR[7:3]);
  assign offset    = port_id[2:0];
  assign empty     = (count_reg == '0);
  assign push      = sample_valid & ~full_reg;
  assign drop      = sample_valid & full_reg;
  assign pop       = read_strobe & decoded & (offset == 3'd3) & ~empty;
  assign wr_ctrl   = write_strobe & decoded & (offset == 3'd4);
  assign wr_thresh = write_strobe & decoded & (offset == 3'd5);
  assign flush     = wr_ctrl & out_port[1];
  assign clr_ovf   = wr_ctrl & out_port[2];
  assign head      = mem[rd_ptr_reg];

  always_comb begin
    count8 = '0;
    count8[ADDR_W:0] = count_reg;
  end

  assign cond = irq_en_reg & (thresh_reg != 8'h00) & (count8 >= thresh_reg);

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count_reg + CNT_ONE;
    else if (pop && !push)
      count_next = count_reg - CNT_ONE;
  end

  // Sample storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
      thresh_reg   <= 8'h00;
    end else begin
      if (clr_ovf)
        overflow_reg <= 1'b0;
      else if (drop)
        overflow_reg <= 1'b1;
      if (wr_ctrl)
        irq_en_reg <= out_port[0];
      if (wr_thresh)
        thresh_reg <= out_port;
    end
  end

`ifdef PB_AUDIO_OVFCNT_EN
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || clr_ovf)
      ovf_cnt_reg <= 8'h00;
    else if (drop && ovf_cnt_reg != 8'hFF)
      ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
  end

  assign ovf_cnt = ovf_cnt_reg;
`else
  assign ovf_cnt = 8'h00;
`endif

  // Ack takes priority over a still-true cond while PENDING.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_state_reg <= ARMED;
    end else if (flush || (wr_ctrl && !out_port[0])) begin
      irq_state_reg <= ARMED;
    end else begin
      case (irq_state_reg)
        ARMED:    if (cond)          irq_state_reg <= PENDING;
        PENDING:  if (interrupt_ack) irq_state_reg <= WAIT_LOW;
        WAIT_LOW: if (!cond)         irq_state_reg <= ARMED;
        default:                     irq_state_reg <= ARMED;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (decoded) begin
      case (offset)
        3'd0: rd_mux = {3'b000, irq_en_reg, irq_state_reg == PENDING,
                        overflow_reg, full_reg, empty};
        3'd1: rd_mux = count8;
        3'd2: rd_mux = empty ? 8'h00 : head[7:0];
        3'd3: rd_mux = empty ? 8'h00 : head[15:8];
        3'd6: rd_mux = ovf_cnt;
        default: rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      in_port_reg <= 8'h00;
    else
      in_port_reg <= rd_mux;
  end

  assign in_port      = in_port_reg;
  assign interrupt    = (irq_state_reg == PENDING);
  assign sample_ready = ~full_reg;

endmodule

// File: tb/tb_pb_audio_port.sv
// Directed vector-table bench for pb_audio_port, plus hand sequences for
// simultaneous push/pop, flush with a pending interrupt, and mid-transfer reset.
module tb_pb_audio_port;

  localparam logic [7:0] B = 8'h20;
`ifdef PB_AUDIO_OVFCNT_EN
  localparam logic [7:0] OVF_EXP = 8'h01;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  localparam logic [2:0] OP_PUSH = 3'd0, OP_RD = 3'd1, OP_POP = 3'd2, OP_WR = 3'd3,
                         OP_IRQ = 3'd4, OP_RDY = 3'd5, OP_IDLE = 3'd6, OP_ACK = 3'd7;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic        read_strobe;
  logic [7:0]  in_port;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];

  pb_audio_port #(.BASE_ADDR(B), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .in_port(in_port), .write_strobe(write_strobe), .out_port(out_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("ok   %-14s got %h", name, act);
    end else begin
      $display("FAIL %-14s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [2:0] op, input logic [7:0] addr,
                              input logic [15:0] data, input logic [7:0] exp,
                              input string name);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic strobe, output logic [7:0] val);
    @(negedge clk);
    port_id     = addr;
    read_strobe = strobe;
    @(negedge clk);
    val         = in_port;
    read_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    @(negedge clk);
    port_id      = addr;
    out_port     = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1; port_id = 8'h00; read_strobe = 1'b0; write_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; sample_valid = 1'b0; sample_data = 16'h0;

    // basic read-out and decode
    add(OP_RD,   B|0, 0, 8'h01, "rst_status");
    add(OP_IRQ,  0,   0, 8'h00, "rst_irq");
    add(OP_RDY,  0,   0, 8'h01, "rst_ready");
    add(OP_PUSH, 0, 16'hA55A, 0, "");
    add(OP_PUSH, 0, 16'h1234, 0, "");
    add(OP_RD,   B|1, 0, 8'h02, "count2");
    add(OP_RD,   B|2, 0, 8'h5A, "lo0");
    add(OP_POP,  B|3, 0, 8'hA5, "hi0");
    add(OP_RD,   B|2, 0, 8'h34, "lo1");
    add(OP_POP,  B|3, 0, 8'h12, "hi1");
    add(OP_RD,   B|1, 0, 8'h00, "count0");
    add(OP_POP,  B|3, 0, 8'h00, "pop_empty");
    add(OP_RD,   B|1, 0, 8'h00, "count_still0");
    add(OP_PUSH, 0, 16'hBEEF, 0, "");
    add(OP_RD,   8'h02, 0, 8'h00, "undecoded");
    add(OP_RD,   B|7, 0, 8'h00, "unmapped");
    add(OP_RD,   B|2, 0, 8'hEF, "lo_beef");
    // fill to full and overflow
    for (int i = 1; i < 16; i++) add(OP_PUSH, 0, 16'h0100 + 16'(i), 0, "");
    add(OP_RD,   B|1, 0, 8'h10, "count16");
    add(OP_RD,   B|0, 0, 8'h02, "status_full");
    add(OP_RDY,  0,   0, 8'h00, "ready_full");
    add(OP_PUSH, 0, 16'hDEAD, 0, "");
    add(OP_RD,   B|0, 0, 8'h06, "status_ovf");
    add(OP_RD,   B|1, 0, 8'h10, "count_ovf");
    add(OP_RD,   B|6, 0, OVF_EXP, "ovf_cnt");
    add(OP_WR,   B|4, 16'h04, 0, "");
    add(OP_RD,   B|0, 0, 8'h02, "ovf_cleared");
    add(OP_RD,   B|6, 0, 8'h00, "ovf_cnt_clr");
    add(OP_RD,   B|3, 0, 8'hBE, "head_kept");
    add(OP_WR,   B|4, 16'h02, 0, "");
    add(OP_RD,   B|1, 0, 8'h00, "flush_count");
    add(OP_RDY,  0,   0, 8'h01, "flush_ready");
    // threshold interrupt
    add(OP_WR,   B|5, 16'h04, 0, "");
    add(OP_WR,   B|4, 16'h01, 0, "");
    for (int i = 0; i < 3; i++) add(OP_PUSH, 0, 16'h1000 + 16'(i), 0, "");
    add(OP_IRQ,  0, 0, 8'h00, "irq_cnt3");
    add(OP_PUSH, 0, 16'h1003, 0, "");
    add(OP_IRQ,  0, 0, 8'h00, "irq_not_early");
    add(OP_IDLE, 0, 0, 0, "");
    add(OP_IRQ,  0, 0, 8'h01, "irq_rise");
    add(OP_RD,   B|0, 0, 8'h18, "status_pend");
    add(OP_ACK,  0, 0, 0, "");
    add(OP_IRQ,  0, 0, 8'h00, "irq_acked");
    add(OP_IDLE, 0, 0, 0, "");
    add(OP_IRQ,  0, 0, 8'h00, "irq_waitlow");
    add(OP_RD,   B|0, 0, 8'h10, "status_wait");
    add(OP_POP,  B|3, 0, 8'h10, "pop_to3");
    add(OP_PUSH, 0, 16'h1004, 0, "");
    add(OP_IDLE, 0, 0, 0, "");
    add(OP_IRQ,  0, 0, 8'h01, "irq_rearm");
    add(OP_WR,   B|4, 16'h00, 0, "");
    add(OP_IRQ,  0, 0, 8'h00, "irq_disable");

    do_reset();
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_PUSH: push(vecs[i].data);
        OP_RD:   begin rd(vecs[i].addr, 1'b0, v); check(vecs[i].name, 16'(v), 16'(vecs[i].exp)); end
        OP_POP:  begin rd(vecs[i].addr, 1'b1, v); check(vecs[i].name, 16'(v), 16'(vecs[i].exp)); end
        OP_WR:   wr(vecs[i].addr, vecs[i].data[7:0]);
        OP_IRQ:  check(vecs[i].name, 16'(interrupt), 16'(vecs[i].exp));
        OP_RDY:  check(vecs[i].name, 16'(sample_ready), 16'(vecs[i].exp));
        OP_IDLE: @(negedge clk);
        OP_ACK:  begin
                   @(negedge clk); interrupt_ack = 1'b1;
                   @(negedge clk); interrupt_ack = 1'b0;
                 end
        default: ;
      endcase
    end

    // Same-cycle push and pop at COUNT = 5 (FIFO holds 1001..1004 here)
    push(16'h1005);
    rd(B|1, 1'b0, v); check("cnt5_before", 16'(v), 16'h0005);
    @(negedge clk);
    port_id = B|3; read_strobe = 1'b1; sample_valid = 1'b1; sample_data = 16'h2000;
    @(negedge clk);
    v = in_port; read_strobe = 1'b0; sample_valid = 1'b0;
    check("pushpop_hi", 16'(v), 16'h0010);
    rd(B|1, 1'b0, v); check("cnt5_after", 16'(v), 16'h0005);
    for (int k = 0; k < 5; k++) begin
      logic [15:0] e;
      e = (k < 4) ? 16'h1002 + 16'(k) : 16'h2000;
      rd(B|2, 1'b0, v); check("order_lo", 16'(v), 16'(e[7:0]));
      rd(B|3, 1'b1, v); check("order_hi", 16'(v), 16'(e[15:8]));
    end

    // Flush while interrupt is high and a sample is offered
    wr(B|5, 8'h02);
    wr(B|4, 8'h01);
    push(16'h4000);
    push(16'h4001);
    @(negedge clk);
    check("irq_preflush", 16'(interrupt), 16'h0001);
    port_id = B|4; out_port = 8'h03; write_strobe = 1'b1;
    sample_valid = 1'b1; sample_data = 16'h3333;
    @(negedge clk);
    write_strobe = 1'b0; sample_valid = 1'b0;
    check("irq_flushed", 16'(interrupt), 16'h0000);
    rd(B|1, 1'b0, v); check("flush_cnt0", 16'(v), 16'h0000);
    rd(B|2, 1'b0, v); check("flush_nodata", 16'(v), 16'h0000);
    check("irq_stays0", 16'(interrupt), 16'h0000);

    // Reset mid-transfer discards contents
    wr(B|4, 8'h00);
    for (int k = 0; k < 16; k++) push(16'h5500 + 16'(k));
    do_reset();
    check("rst_in_port", 16'(in_port), 16'h0000);
    check("rst_ready2", 16'(sample_ready), 16'h0001);
    rd(B|1, 1'b0, v); check("rst_count", 16'(v), 16'h0000);
    rd(B|0, 1'b0, v); check("rst_status2", 16'(v), 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
